// File: rtl/varint_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : varint_pkg
//  Brief    : Shared constants, protobuf field-type codes and the FSM state
//             type for the varint fetch/decode block.
//  Revision : 1.0 - initial release
// ============================================================================
package varint_pkg;

    // Longest legal varint, and silent-responder cycles tolerated per byte
    localparam int VARINT_MAX_BYTES = 10;
    localparam int VARINT_TIMEOUT   = 32;

    // Protobuf field-type codes that change how the value is finalised
    localparam logic [4:0] FT_FLOAT    = 5'd2;
    localparam logic [4:0] FT_INT64    = 5'd3;
    localparam logic [4:0] FT_UINT64   = 5'd4;
    localparam logic [4:0] FT_INT32    = 5'd5;
    localparam logic [4:0] FT_FIXED32  = 5'd7;
    localparam logic [4:0] FT_UINT32   = 5'd13;
    localparam logic [4:0] FT_SFIXED32 = 5'd15;
    localparam logic [4:0] FT_SINT32   = 5'd17;
    localparam logic [4:0] FT_SINT64   = 5'd18;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_FINISH = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/zigzag_dec.sv
`default_nettype none
// ============================================================================
//  Module   : zigzag_dec
//  Brief    : Combinational zigzag decode, 32-bit (sign-extended to 64) or
//             64-bit: out = (n >> 1) ^ -(n & 1).
//  Revision : 1.0 - initial release
// ============================================================================
module zigzag_dec (
    input  logic [63:0] in_val,
    input  logic        is_32,
    output logic [63:0] out_val
);

    logic [31:0] w_z32;
    logic [63:0] w_z64;

    assign w_z32   = {1'b0, in_val[31:1]} ^ {32{in_val[0]}};
    assign w_z64   = {1'b0, in_val[63:1]} ^ {64{in_val[0]}};
    assign out_val = is_32 ? {{32{w_z32[31]}}, w_z32} : w_z64;

endmodule
`default_nettype wire

// File: rtl/varint_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : varint_fetch_decode
//  Brief    : Fetches a protobuf varint one byte per request (addresses walk
//             downward from src_addr), accumulates the 7-bit groups and
//             finalises the value according to the field type.
//             Optional feature: define VARINT_ZIGZAG_EN to decode sint32 /
//             sint64 through zigzag_dec; otherwise sint32 behaves as int32
//             and sint64 as a raw value.
//  Revision : 1.0 - initial release
// ============================================================================
module varint_fetch_decode
    import varint_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [63:0] src_addr,
    input  logic [4:0]  field_type,
    output logic        dram_req,
    output logic [63:0] dram_addr,
    output logic        dram_rdwr,
    input  logic [7:0]  dram_rdata,
    input  logic        dram_rvalid,
    output logic [63:0] value,
    output logic        done,
    output logic [3:0]  bytes_read,
    output logic        error
);

    state_t      state_q, state_d;
    logic [63:0] addr_q,  addr_d;
    logic [4:0]  type_q,  type_d;
    logic [63:0] acc_q,   acc_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        err_q,   err_d;
    logic [63:0] value_q, value_d;
    logic [4:0]  tmo_q,   tmo_d;

    logic [6:0]  w_shamt;
    logic [63:0] w_acc_new;
    logic [63:0] w_final;
    logic [31:0] w_lo;
    logic [63:0] w_sext;

    // Byte k lands at bit 7k; for k=9 the shift of 63 keeps only payload bit 0
    assign w_shamt   = 7'(cnt_q) * 7'd7;
    assign w_acc_new = acc_q | ({57'd0, dram_rdata[6:0]} << w_shamt);
    assign w_lo      = w_acc_new[31:0];
    assign w_sext    = {{32{w_lo[31]}}, w_lo};

`ifdef VARINT_ZIGZAG_EN
    logic [63:0] w_zz;

    zigzag_dec u_zigzag_dec (
        .in_val  (w_acc_new),
        .is_32   (type_q == FT_SINT32),
        .out_val (w_zz)
    );

    // Type-dependent finalisation of the completed accumulator
    always_comb begin
        w_final = w_acc_new;
        case (type_q)
            FT_INT32:                                  w_final = w_sext;
            FT_FLOAT, FT_FIXED32, FT_UINT32, FT_SFIXED32: w_final = {32'd0, w_lo};
            FT_SINT32, FT_SINT64:                      w_final = w_zz;
            default:                                   w_final = w_acc_new;
        endcase
    end
`else
    // Type-dependent finalisation; sint32 falls back to int32, sint64 to raw
    always_comb begin
        w_final = w_acc_new;
        case (type_q)
            FT_INT32, FT_SINT32:                       w_final = w_sext;
            FT_FLOAT, FT_FIXED32, FT_UINT32, FT_SFIXED32: w_final = {32'd0, w_lo};
            default:                                   w_final = w_acc_new;
        endcase
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            type_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            value_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            value_q <= value_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state logic; the result and error are registered on the edge that
    // enters FINISH so they are valid alongside the done pulse
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        value_d = value_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    addr_d  = src_addr;
                    type_d  = field_type;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!en) begin
                    state_d = S_IDLE;
                end else if (dram_rvalid) begin
                    acc_d = w_acc_new;
                    cnt_d = cnt_q + 4'd1;
                    if (dram_rdata[7] && (cnt_q == 4'(VARINT_MAX_BYTES - 1))) begin
                        err_d   = 1'b1;
                        value_d = '0;
                        state_d = S_FINISH;
                    end else if (!dram_rdata[7]) begin
                        value_d = w_final;
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (tmo_q == 5'(VARINT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    value_d = '0;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 5'd1;
                end
            end
            S_FINISH: state_d = S_HOLD;
            S_HOLD: begin
                if (!en) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dram_req   = (state_q == S_REQ);
    assign dram_addr  = addr_q - {60'd0, cnt_q};
    assign dram_rdwr  = 1'b1;
    assign done       = (state_q == S_FINISH);
    assign value      = value_q;
    assign bytes_read = cnt_q;
    assign error      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_varint_fetch_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_varint_fetch_decode
//  Brief    : Self-checking bench: byte-memory responder, behavioural varint
//             model and a per-cycle monitor on the request/done interface.
//             Expectations follow VARINT_ZIGZAG_EN when it is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_varint_fetch_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [63:0] src_addr = '0;
    logic [4:0]  field_type = '0;
    logic        dram_req;
    logic [63:0] dram_addr;
    logic        dram_rdwr;
    logic [7:0]  dram_rdata = '0;
    logic        dram_rvalid = 1'b0;
    logic [63:0] value;
    logic        done;
    logic [3:0]  bytes_read;
    logic        error;

    varint_fetch_decode dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .src_addr    (src_addr),
        .field_type  (field_type),
        .dram_req    (dram_req),
        .dram_addr   (dram_addr),
        .dram_rdwr   (dram_rdwr),
        .dram_rdata  (dram_rdata),
        .dram_rvalid (dram_rvalid),
        .value       (value),
        .done        (done),
        .bytes_read  (bytes_read),
        .error       (error)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Responder / expectation state shared with the monitor
    logic [7:0]  mem [16];
    logic [63:0] base = '0;
    logic [63:0] paddr = '0;
    int          lat = 1;
    bit          silent = 0;
    bit          garbage = 0;
    bit          gpend = 0;
    bit          pend = 0;
    bit          armed = 0;
    int          due = 0;
    int          last_rv = 0;
    int          nreq = 0;
    int          ndone = 0;
    logic [63:0] exp_v = '0;
    logic [3:0]  exp_br = '0;
    logic        exp_e = 1'b0;
    bit          exp_tmo = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Reference: scan the byte stream, then apply the field-type rule
    function automatic void model(input logic [4:0] ft);
        logic [63:0] acc;
        logic [31:0] lo;
        logic [31:0] z;
        int k;
        acc = '0;
        exp_e = 1'b0;
        exp_tmo = 0;
        for (k = 0; k < 10; k++) begin
            acc = acc | ({56'd0, mem[k] & 8'h7f} << (7 * k));
            if (mem[k][7] == 1'b0) break;
        end
        if (k == 10) begin
            exp_e = 1'b1;
            exp_v = '0;
            exp_br = 4'd10;
            return;
        end
        exp_br = 4'(k + 1);
        lo = acc[31:0];
        case (ft)
            5'd5: exp_v = {{32{lo[31]}}, lo};
            5'd2, 5'd7, 5'd13, 5'd15: exp_v = {32'd0, lo};
`ifdef VARINT_ZIGZAG_EN
            5'd17: begin
                z = (lo >> 1) ^ (32'd0 - (lo & 32'd1));
                exp_v = {{32{z[31]}}, z};
            end
            5'd18: exp_v = (acc >> 1) ^ (64'd0 - (acc & 64'd1));
`else
            5'd17: exp_v = {{32{lo[31]}}, lo};
`endif
            default: exp_v = acc;
        endcase
    endfunction

    // Monitor and memory responder, acting on the falling edge
    initial begin
        logic [63:0] off;
        forever begin
            @(negedge clk);
            dram_rvalid = 1'b0;
            dram_rdata  = 8'($urandom);
            chk("dram_rdwr", {63'd0, dram_rdwr}, 64'd1);
            if (pend && cyc == due) begin
                off = base - paddr;
                dram_rvalid = 1'b1;
                dram_rdata  = (off < 64'd16) ? mem[off[3:0]] : 8'h00;
                pend = 0;
                last_rv = cyc;
                gpend = garbage;
            end else if (gpend) begin
                dram_rvalid = 1'b1;
                gpend = 0;
            end
            if (dram_req) begin
                chk("dram_addr", dram_addr, base - 64'(nreq));
                nreq++;
                if (!silent) begin
                    pend = 1;
                    due = cyc + lat;
                    paddr = dram_addr;
                end
            end
            if (done) begin
                if (!armed) begin
                    chk("spurious_done", {63'd0, done}, 64'd0);
                end else begin
                    armed = 0;
                    chk("value", value, exp_v);
                    chk("bytes_read", {60'd0, bytes_read}, {60'd0, exp_br});
                    chk("error", {63'd0, error}, {63'd0, exp_e});
                    if (!exp_tmo) chk("done_latency", 64'(cyc), 64'(last_rv + 1));
                end
                ndone++;
            end
        end
    end

    task automatic run_txn(input logic [4:0] ft, input logic [63:0] b, input int l, input int hold);
        int n0;
        int k;
        if (silent) begin
            exp_v = '0; exp_br = '0; exp_e = 1'b1; exp_tmo = 1;
        end else begin
            model(ft);
        end
        base = b; lat = l; nreq = 0; n0 = ndone; armed = 1;
        src_addr = b; field_type = ft; en = 1'b1;
        k = 0;
        while (ndone == n0 && k < 400) begin
            @(posedge clk); #2;
            k++;
        end
        chk("done_seen", 64'(ndone != n0), 64'd1);
        armed = 0;
        src_addr = {$urandom, $urandom};
        field_type = 5'($urandom);
        repeat (hold) @(posedge clk);
        #2;
        chk("one_done", 64'(ndone), 64'(n0 + 1));
        chk("value_held", value, exp_v);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    initial begin
        int n;
        logic [4:0] ft;
        logic [4:0] types [10];
        types = '{5'd2, 5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd13, 5'd15, 5'd17, 5'd18};
        clear_mem();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req", {63'd0, dram_req}, 64'd0);
        chk("rst_addr", dram_addr, 64'd0);
        chk("rst_value", value, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_br", {60'd0, bytes_read}, 64'd0);
        chk("rst_err", {63'd0, error}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Single byte, uint32, one-cycle responder
        clear_mem(); mem[0] = 8'h05;
        run_txn(5'd13, 64'h100, 1, 3);
        chk("lit_single_value", value, 64'd5);
        chk("lit_single_br", {60'd0, bytes_read}, 64'd1);
        chk("lit_single_err", {63'd0, error}, 64'd0);

        // Two bytes, uint64: 0xAC,0x02 -> 300, addresses 0x100 then 0xFF
        clear_mem(); mem[0] = 8'hAC; mem[1] = 8'h02;
        run_txn(5'd4, 64'h100, 1, 3);
        chk("lit_300_value", value, 64'd300);
        chk("lit_300_br", {60'd0, bytes_read}, 64'd2);
        chk("lit_300_nreq", 64'(nreq), 64'd2);

        // sint32 of 0x03
        clear_mem(); mem[0] = 8'h03;
        run_txn(5'd17, 64'h100, 2, 3);
`ifdef VARINT_ZIGZAG_EN
        chk("lit_sint32", value, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        chk("lit_sint32", value, 64'd3);
`endif

        // Ten-byte maximum: nine 0xFF then 0x01
        clear_mem();
        for (int i = 0; i < 9; i++) mem[i] = 8'hFF;
        mem[9] = 8'h01;
        run_txn(5'd4, 64'h100, 1, 3);
        chk("lit_max_value", value, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("lit_max_br", {60'd0, bytes_read}, 64'd10);

        // Eleven-byte input: tenth byte 0x81 is malformed
        mem[9] = 8'h81; mem[10] = 8'h01;
        run_txn(5'd4, 64'h100, 1, 3);
        chk("lit_long_err", {63'd0, error}, 64'd1);
        chk("lit_long_value", value, 64'd0);

        // Silent responder -> timeout, then en held with no second done
        silent = 1;
        run_txn(5'd4, 64'h300, 1, 40);
        chk("tmo_err", {63'd0, error}, 64'd1);
        chk("tmo_br", {60'd0, bytes_read}, 64'd0);
        silent = 0;

        // Abort by dropping en while waiting; the late response is ignored
        clear_mem(); mem[0] = 8'h05;
        armed = 0; base = 64'h400; nreq = 0; lat = 8;
        src_addr = 64'h400; field_type = 5'd4; en = 1'b1;
        repeat (3) @(posedge clk);
        #2 en = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        chk("abort_br", {60'd0, bytes_read}, 64'd0);

        // Reset while waiting, then a late rvalid
        silent = 1; armed = 0; base = 64'h200; nreq = 0;
        src_addr = 64'h200; field_type = 5'd4; en = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1; en = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #1 dram_rvalid = 1'b1; dram_rdata = 8'h05;
        repeat (10) @(posedge clk);
        #2;
        chk("rstw_value", value, 64'd0);
        chk("rstw_br", {60'd0, bytes_read}, 64'd0);
        chk("rstw_err", {63'd0, error}, 64'd0);
        chk("rstw_req", {63'd0, dram_req}, 64'd0);
        chk("rstw_addr", dram_addr, 64'd0);
        chk("rstw_done", {63'd0, done}, 64'd0);
        silent = 0;

        // Randomised transactions
        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 11);
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < n - 1 && i < 10; i++) mem[i][7] = 1'b1;
            if (n <= 10) mem[n - 1][7] = 1'b0;
            ft = types[$urandom_range(0, 9)];
            garbage = 1'($urandom);
            run_txn(ft, {$urandom, $urandom}, $urandom_range(1, 4), 2);
        end
        garbage = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
